rsfq_tie_array_sync: RTL and testbench
======================================

// Module: rsfq_tie_array_sync
// PURPOSE
//  Clocked, parametrised successor to the always-0 async tie cell.
//  Provides NCH independent tie-off/sink channels. Each channel drives its output per a
//  runtime-selectable mode: constant 0, constant 1 (one pulse every clock), delayed pass,
//  or delayed invert. Each channel also counts the input pulses it absorbs.
//  Used in RSFQ behavioural netlists to terminate unused nets and to monitor them.
// PARAMETERS
//  NCH       4      number of channels (1..32)
//  DEPTH     1      PASS/INVERT latency in clocks (1..8)
//  CNT_W     8      width of each saturating absorbed-pulse counter (2..16)
//  INIT_MODE 0      NCH*2-bit vector; channel i's reset mode is INIT_MODE[2i+1:2i]
// PORTS
//  clk       in   1               clock; all state updates on posedge
//  rst       in   1               synchronous, active-high reset
//  a         in   NCH             input pulse/level per channel (sampled at posedge)
//  q         out  NCH             registered output per channel
//  cfg_we    in   1               write the mode of channel cfg_ch
//  cfg_ch    in   $clog2(NCH)     target channel of the config write
//  cfg_mode  in   2               new mode value
//  cnt_clr   in   NCH             per-channel counter clear
//  cnt_sel   in   $clog2(NCH)     counter readback select
//  cnt_out   out  CNT_W           registered count of the selected channel
// BEHAVIOUR
//  - Reset (clk edge with rst=1): q=0, cnt_out=0, all counters=0, delay lines=0,
//    mode[i]=INIT_MODE[2i+1:2i]. rst has priority over every other input.
//  - Modes: 00 CONST0 -> q[i]=0; 01 CONST1 -> q[i]=1 on every clock;
//    10 PASS -> q[i] = a[i] sampled DEPTH clocks earlier;
//    11 INVERT -> q[i] = ~a[i] sampled DEPTH clocks earlier.
//  - Output update: q[i] is registered. In CONST1, q[i] is 1 on the first edge after rst
//    deasserts. In PASS/INVERT, a[i] at edge t appears on q[i] at edge t+DEPTH.
//  - Delay line: always shifts, in every mode. A switch to PASS/INVERT therefore outputs
//    the history already captured. The switch does not flush or zero the line.
//  - Config: on an edge with cfg_we=1, mode[cfg_ch] <= cfg_mode. The new mode governs q
//    from the following edge; the edge that writes the mode still uses the old mode.
//    cfg_ch >= NCH: the write is ignored.
//  - Counter: cnt[i] increments on each edge with a[i]=1, in all modes.
//    Saturates at 2^CNT_W-1 with no wrap.
//  - Clear: cnt_clr[i]=1 sets cnt[i]=0 on that edge. Clear wins over a same-edge increment.
//  - Readback: cnt_out <= cnt[cnt_sel], one-clock latency, showing the pre-edge count.
//    cnt_sel >= NCH gives cnt_out <= 0.
//  - Reset mid-operation: in-flight delay-line pulses are discarded.
//    q is 0 on the next edge regardless of mode.
//  - No X propagation: X/Z on a[i] is treated as 0 for counting and delay
//    (the bench checks this).
// STRUCTURE
//  - Package rsfq_tie_pkg: typedef tie_mode_e {MODE_CONST0=2'd0, MODE_CONST1=2'd1,
//    MODE_PASS=2'd2, MODE_INVERT=2'd3}; localparam MAX_DEPTH=8; localparam MAX_NCH=32.
//  - Sub-module rsfq_tie_chan (per channel): mode register, DEPTH delay line,
//    output register, saturating counter. Top level adds generate-loop instantiation,
//    cfg decode and the cnt_out mux/register.
// TESTING
//  1. Reset with INIT_MODE=0, NCH=4; drive a=4'hF for 5 clocks
//     -> q=0 throughout; cnt_sel=2 gives cnt_out=5 one clock later.
//  2. cfg_we, ch1 = CONST1 at edge t -> q[1]=0 at t, then q[1]=1 at t+1 and every later edge.
//  3. DEPTH=3, ch0 = PASS; single pulse a[0]=1 at edge 10 -> q[0]=1 only at edge 13.
//     In INVERT, q[0]=0 only at edge 13.
//  4. CNT_W=2; 6 pulses on a[3] -> cnt=3 (saturated).
//     cnt_clr[3] with a[3]=1 on the same edge -> cnt=0.
//  5. PASS with a pulse in flight, rst at the edge before the scheduled exit
//     -> q[0] stays 0 and mode returns to INIT_MODE.
//  6. cfg_ch=NCH or cnt_sel=NCH -> no mode change and cnt_out=0.

Source files
------------

// File: rtl/rsfq_tie_array_sync_pkg.sv
// Shared types and limits for the clocked RSFQ tie/sink channel array.
package rsfq_tie_pkg;

    typedef enum logic [1:0] {
        MODE_CONST0 = 2'd0,
        MODE_CONST1 = 2'd1,
        MODE_PASS   = 2'd2,
        MODE_INVERT = 2'd3
    } tie_mode_e;

    localparam int MAX_DEPTH = 8;
    localparam int MAX_NCH   = 32;

    // A single channel still needs a 1-bit select so the ports stay legal.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rsfq_tie_array_sync_if.sv
// Pulse, configuration and counter-readback bundle for rsfq_tie_array_sync.
interface rsfq_tie_array_sync_if
    import rsfq_tie_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    localparam int SEL_W = sel_width(NCH);

    logic [NCH-1:0]   a;
    logic [NCH-1:0]   q;
    logic             cfg_we;
    logic [SEL_W-1:0] cfg_ch;
    tie_mode_e        cfg_mode;
    logic [NCH-1:0]   cnt_clr;
    logic [SEL_W-1:0] cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    modport master (
        output a, cfg_we, cfg_ch, cfg_mode, cnt_clr, cnt_sel,
        input  q, cnt_out
    );

    modport slave (
        input  a, cfg_we, cfg_ch, cfg_mode, cnt_clr, cnt_sel,
        output q, cnt_out
    );

endinterface

// File: rtl/rsfq_tie_array_sync_chan.sv
// One tie/sink channel: mode register, input delay line, registered output and
// saturating absorbed-pulse counter.
module rsfq_tie_chan
    import rsfq_tie_pkg::*;
#(
    parameter int         DEPTH = 1,
    parameter int         CNT_W = 8,
    parameter logic [1:0] INIT  = 2'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             mode_we,
    input  tie_mode_e        mode_wdata,
    input  logic             clr,
    output logic             q,
    output logic [CNT_W-1:0] cnt
);

    tie_mode_e        mode;
    logic [DEPTH-1:0] line;
    logic             a_clean;
    logic             tap;

    // An unknown input falls through to the else path and is absorbed as 0.
    always_comb begin
        // NOTE: assign a default before any condition so no latch is inferred.
        a_clean = 1'b0;
        if (a) a_clean = 1'b1;
    end

    assign tap = line[DEPTH-1];

    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // which is what gives the delay line its exact DEPTH-clock latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= tie_mode_e'(INIT);
            line <= '0;
            q    <= 1'b0;
            cnt  <= '0;
        end else begin
            if (mode_we) mode <= mode_wdata;

            line[0] <= a_clean;
            for (int k = 1; k < DEPTH; k++) line[k] <= line[k-1];

            unique case (mode)
                MODE_CONST0: q <= 1'b0;
                MODE_CONST1: q <= 1'b1;
                MODE_PASS:   q <= tap;
                MODE_INVERT: q <= ~tap;
            endcase

            if (clr)                         cnt <= '0;
            else if (a_clean && cnt != '1)   cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rsfq_tie_array_sync.sv
// Array of NCH tie/sink channels with runtime mode writes and registered
// counter readback.
module rsfq_tie_array_sync
    import rsfq_tie_pkg::*;
#(
    parameter int               NCH       = 4,
    parameter int               DEPTH     = 1,
    parameter int               CNT_W     = 8,
    parameter logic [2*NCH-1:0] INIT_MODE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    rsfq_tie_array_sync_if.slave  bus
);

    logic [CNT_W-1:0] cnt_arr [NCH];
    logic [NCH-1:0]   q_vec;
    logic [CNT_W-1:0] cnt_out_r;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic we;

        // Out-of-range channel numbers match no instance, so the write is dropped.
        assign we = bus.cfg_we && (32'(bus.cfg_ch) == i);

        rsfq_tie_chan #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W),
            .INIT  (INIT_MODE[2*i +: 2])
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .a          (bus.a[i]),
            .mode_we    (we),
            .mode_wdata (bus.cfg_mode),
            .clr        (bus.cnt_clr[i]),
            .q          (q_vec[i]),
            .cnt        (cnt_arr[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)                            cnt_out_r <= '0;
        else if (32'(bus.cnt_sel) < NCH)    cnt_out_r <= cnt_arr[bus.cnt_sel];
        else                                cnt_out_r <= '0;
    end

    assign bus.q       = q_vec;
    assign bus.cnt_out = cnt_out_r;

endmodule

// File: tb/tb_rsfq_tie_array_sync.sv
// Scoreboard bench: two configurations of rsfq_tie_array_sync run in lockstep
// against a cycle model; expected outputs are queued per edge and compared after it.
module tb_rsfq_tie_array_sync;
    import rsfq_tie_pkg::*;

    localparam int         P_NCH0   = 4;
    localparam int         P_DEPTH0 = 3;
    localparam int         P_CNTW0  = 8;
    localparam logic [7:0] P_INIT0  = 8'h00;
    localparam int         P_NCH1   = 5;
    localparam int         P_DEPTH1 = 1;
    localparam int         P_CNTW1  = 2;
    // ch4 PASS, ch3 CONST0, ch2 INVERT, ch1 CONST1, ch0 PASS
    localparam logic [9:0] P_INIT1  = 10'b10_00_11_01_10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rsfq_tie_array_sync_if #(.NCH(P_NCH0), .CNT_W(P_CNTW0)) bus0 ();
    rsfq_tie_array_sync_if #(.NCH(P_NCH1), .CNT_W(P_CNTW1)) bus1 ();

    rsfq_tie_array_sync #(
        .NCH(P_NCH0), .DEPTH(P_DEPTH0), .CNT_W(P_CNTW0), .INIT_MODE(P_INIT0)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    rsfq_tie_array_sync #(
        .NCH(P_NCH1), .DEPTH(P_DEPTH1), .CNT_W(P_CNTW1), .INIT_MODE(P_INIT1)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic [7:0]  q0;
        logic [15:0] c0;
        logic [7:0]  q1;
        logic [15:0] c1;
    } sb_item_t;

    sb_item_t sb [$];

    int n_checks = 0;
    int n_pass   = 0;
    bit rand1    = 1'b0;

    // Model state, indexed [dut][channel]
    int         m_mode [2][8];
    int         m_init [2][8];
    int         m_cnt  [2][8];
    bit         m_hist [2][8][8];
    logic [7:0] m_q    [2];
    int         m_cout [2];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_edge(input int d, input bit r, input logic [7:0] a,
                              input bit we, input int ch, input int md,
                              input logic [7:0] clr, input int sel);
        int nch;
        int depth;
        int cmax;
        bit ab;
        bit tap;
        nch   = (d == 0) ? P_NCH0 : P_NCH1;
        depth = (d == 0) ? P_DEPTH0 : P_DEPTH1;
        cmax  = (d == 0) ? (1 << P_CNTW0) - 1 : (1 << P_CNTW1) - 1;
        if (r) begin
            m_q[d]    = '0;
            m_cout[d] = 0;
            for (int i = 0; i < 8; i++) begin
                m_cnt[d][i]  = 0;
                m_mode[d][i] = m_init[d][i];
                for (int k = 0; k < 8; k++) m_hist[d][i][k] = 1'b0;
            end
        end else begin
            m_cout[d] = (sel < nch) ? m_cnt[d][sel] : 0;
            for (int i = 0; i < nch; i++) begin
                ab  = (a[i] === 1'b1);
                tap = m_hist[d][i][depth-1];
                case (m_mode[d][i])
                    0:       m_q[d][i] = 1'b0;
                    1:       m_q[d][i] = 1'b1;
                    2:       m_q[d][i] = tap;
                    default: m_q[d][i] = ~tap;
                endcase
                for (int k = depth - 1; k > 0; k--) m_hist[d][i][k] = m_hist[d][i][k-1];
                m_hist[d][i][0] = ab;
                if (clr[i] === 1'b1)        m_cnt[d][i] = 0;
                else if (ab && m_cnt[d][i] < cmax) m_cnt[d][i]++;
            end
            if (we && ch < nch) m_mode[d][ch] = md;
        end
    endtask

    task automatic step(input string tag);
        sb_item_t it;
        sb_item_t got;
        if (rand1) begin
            bus1.a        = 5'($urandom);
            bus1.cfg_we   = ($urandom_range(0, 3) == 0);
            bus1.cfg_ch   = 3'($urandom_range(0, 7));
            bus1.cfg_mode = tie_mode_e'($urandom_range(0, 3));
            bus1.cnt_clr  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            bus1.cnt_sel  = 3'($urandom_range(0, 7));
        end
        model_edge(0, rst, 8'(bus0.a), bus0.cfg_we, int'(bus0.cfg_ch),
                   int'(bus0.cfg_mode), 8'(bus0.cnt_clr), int'(bus0.cnt_sel));
        model_edge(1, rst, 8'(bus1.a), bus1.cfg_we, int'(bus1.cfg_ch),
                   int'(bus1.cfg_mode), 8'(bus1.cnt_clr), int'(bus1.cnt_sel));
        it.q0 = m_q[0];
        it.c0 = 16'(m_cout[0]);
        it.q1 = m_q[1];
        it.c1 = 16'(m_cout[1]);
        sb.push_back(it);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, "/q0"},   int'(bus0.q),       int'(got.q0[P_NCH0-1:0]));
        check({tag, "/cnt0"}, int'(bus0.cnt_out), int'(got.c0));
        check({tag, "/q1"},   int'(bus1.q),       int'(got.q1[P_NCH1-1:0]));
        check({tag, "/cnt1"}, int'(bus1.cnt_out), int'(got.c1));
    endtask

    task automatic cfg0(input int ch, input tie_mode_e md);
        bus0.cfg_we   = 1'b1;
        bus0.cfg_ch   = 2'(ch);
        bus0.cfg_mode = md;
    endtask

    initial begin
        logic [7:0] init0;
        logic [9:0] init1;
        init0 = P_INIT0;
        init1 = P_INIT1;
        for (int i = 0; i < 8; i++) begin
            m_init[0][i] = (i < P_NCH0) ? int'(init0[2*i +: 2]) : 0;
            m_init[1][i] = (i < P_NCH1) ? int'(init1[2*i +: 2]) : 0;
        end

        rst = 1'b1;
        bus0.a = '0; bus0.cfg_we = 1'b0; bus0.cfg_ch = '0; bus0.cfg_mode = MODE_CONST0;
        bus0.cnt_clr = '0; bus0.cnt_sel = '0;
        bus1.a = '0; bus1.cfg_we = 1'b0; bus1.cfg_ch = '0; bus1.cfg_mode = MODE_CONST0;
        bus1.cnt_clr = '0; bus1.cnt_sel = '0;
        step("reset");
        step("reset");
        check("reset_q0", int'(bus0.q), 0);
        check("reset_cnt0", int'(bus0.cnt_out), 0);
        rst = 1'b0;
        rand1 = 1'b1;

        // Constant-0 default: pulses are absorbed and counted
        bus0.a = 4'hF;
        bus0.cnt_sel = 2'd2;
        for (int i = 0; i < 5; i++) step("t1_absorb");
        bus0.a = 4'h0;
        step("t1_read");
        check("t1_cnt5", int'(bus0.cnt_out), 5);

        // Mode write takes effect one edge after the writing edge
        cfg0(1, MODE_CONST1);
        step("t2_write");
        check("t2_q1_write_edge", int'(bus0.q[1]), 0);
        bus0.cfg_we = 1'b0;
        step("t2_after");
        check("t2_q1_next_edge", int'(bus0.q[1]), 1);
        step("t2_after");

        // PASS and INVERT latency with DEPTH=3
        cfg0(0, MODE_PASS);
        step("t3_cfg_pass");
        bus0.cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) step("t3_flush");
        bus0.a[0] = 1'b1;
        step("t3_pulse");
        bus0.a[0] = 1'b0;
        step("t3_p1");
        check("t3_pass_p1", int'(bus0.q[0]), 0);
        step("t3_p2");
        check("t3_pass_p2", int'(bus0.q[0]), 0);
        step("t3_p3");
        check("t3_pass_p3", int'(bus0.q[0]), 1);
        step("t3_p4");
        check("t3_pass_p4", int'(bus0.q[0]), 0);
        cfg0(0, MODE_INVERT);
        step("t3_cfg_inv");
        bus0.cfg_we = 1'b0;
        step("t3_inv_idle");
        check("t3_inv_idle", int'(bus0.q[0]), 1);
        bus0.a[0] = 1'b1;
        step("t3_inv_pulse");
        bus0.a[0] = 1'b0;
        step("t3_inv_p1");
        step("t3_inv_p2");
        check("t3_inv_p2", int'(bus0.q[0]), 1);
        step("t3_inv_p3");
        check("t3_inv_p3", int'(bus0.q[0]), 0);
        step("t3_inv_p4");
        check("t3_inv_p4", int'(bus0.q[0]), 1);

        // Reset drops an in-flight pulse and restores the reset modes
        cfg0(0, MODE_PASS);
        step("t5_cfg");
        bus0.cfg_we = 1'b0;
        bus0.a[0] = 1'b1;
        step("t5_pulse");
        bus0.a[0] = 1'b0;
        step("t5_p1");
        rst = 1'b1;
        step("t5_rst");
        check("t5_q_at_rst", int'(bus0.q), 0);
        rst = 1'b0;
        step("t5_p3");
        check("t5_q0_exit", int'(bus0.q[0]), 0);
        check("t5_ch1_init", int'(bus0.q[1]), 0);
        step("t5_p4");

        // Unknown input counts and propagates as 0
        cfg0(2, MODE_PASS);
        bus0.cnt_sel = 2'd2;
        step("tx_cfg");
        bus0.cfg_we = 1'b0;
        bus0.a[2] = 1'bx;
        step("tx_x");
        bus0.a = '0;
        for (int i = 0; i < 4; i++) step("tx_drain");

        // Saturation and clear priority on the 2-bit counter configuration
        rand1 = 1'b0;
        bus1.a = '0; bus1.cfg_we = 1'b0; bus1.cnt_sel = 3'd3;
        bus1.cnt_clr = 5'h1F;
        step("t4_clear_all");
        bus1.cnt_clr = '0;
        bus1.a = 5'b01000;
        for (int i = 0; i < 6; i++) step("t4_pulse");
        bus1.a = '0;
        step("t4_read");
        check("t4_saturated", int'(bus1.cnt_out), 3);
        bus1.a = 5'b01000;
        bus1.cnt_clr = 5'b01000;
        step("t4_clr_vs_inc");
        bus1.a = '0;
        bus1.cnt_clr = '0;
        step("t4_read_clr");
        check("t4_cleared", int'(bus1.cnt_out), 0);

        // Out-of-range channel write and counter select
        bus1.cfg_we = 1'b1;
        bus1.cfg_ch = 3'd5;
        bus1.cfg_mode = MODE_INVERT;
        bus1.cnt_sel = 3'd5;
        bus1.a = 5'h1F;
        step("t6_oor_write");
        bus1.cfg_ch = 3'd7;
        step("t6_oor_write7");
        bus1.cfg_we = 1'b0;
        step("t6_oor_read");
        check("t6_sel_oor", int'(bus1.cnt_out), 0);
        bus1.a = '0;
        step("t6_hold");

        rand1 = 1'b1;
        for (int i = 0; i < 40; i++) step("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
